countdown_sequencer: RTL and testbench

Round controller for the two-digit BCD countdown timer. Loads a preset count, produces one-cycle `decrement` strobes at a fixed prescaled rate, and supports pause, abort and expiry detection from the timer's digit feedback. Sits between the game-round logic (start/pause/abort) and the countdown datapath, driving its `reconfig`, `setDigit_tens/units`, `decrement` and `reset_timer` inputs.

---
 rtl/countdown_sequencer_pkg.sv | 26 ++
 rtl/countdown_sequencer_if.sv | 53 +++++
 rtl/countdown_sequencer_prescaler.sv | 49 ++++
 rtl/countdown_sequencer.sv | 156 +++++++++++++++
 tb/tb_countdown_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/countdown_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
// Shared types for the countdown round controller: the controller state
// encoding, a BCD digit type, the largest legal BCD digit and a helper that
// clamps an out-of-range digit to 9.
// -----------------------------------------------------------------------------
package countdown_pkg;

  typedef enum logic [2:0] {
    CD_IDLE,
    CD_LOAD,
    CD_RUN,
    CD_PAUSE,
    CD_EXPIRED
  } cd_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Digits A..F cannot be shown by the timer, so they are saturated to 9
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// -----------------------------------------------------------------------------
// countdown_sequencer_if
// Bundles the round-control inputs, the timer digit feedback and the strobes
// sent to the BCD countdown datapath.
//   master : the sequencer side (drives strobes, load digits and status)
//   slave  : the environment side (game-round logic plus timer feedback)
// Signals:
//   start/pause/abort           round control levels
//   preset_tens/preset_units    BCD start value
//   digit_tens/digit_units      timer feedback
//   reconfig, setDigit_*        load strobe and clamped load value
//   decrement, reset_timer      count-down and clear strobes
//   running, expired, warn      status
// -----------------------------------------------------------------------------
interface countdown_sequencer_if;
  import countdown_pkg::*;

  logic       start;
  logic       pause;
  logic       abort;
  bcd_digit_t preset_tens;
  bcd_digit_t preset_units;
  bcd_digit_t digit_tens;
  bcd_digit_t digit_units;

  logic       reconfig;
  bcd_digit_t setDigit_tens;
  bcd_digit_t setDigit_units;
  logic       decrement;
  logic       reset_timer;
  logic       running;
  logic       expired;
  logic       warn;

  modport master (
    input  start, pause, abort,
    input  preset_tens, preset_units,
    input  digit_tens, digit_units,
    output reconfig, setDigit_tens, setDigit_units,
    output decrement, reset_timer,
    output running, expired, warn
  );

  modport slave (
    output start, pause, abort,
    output preset_tens, preset_units,
    output digit_tens, digit_units,
    input  reconfig, setDigit_tens, setDigit_units,
    input  decrement, reset_timer,
    input  running, expired, warn
  );

endinterface

// File: rtl/countdown_sequencer_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the clock down to one tick every TICK_DIV cycles. The count runs
// 0..TICK_DIV-1 while enable is high and freezes while it is low, so a paused
// round resumes exactly where it left off.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset, count to 0
//   clear  in  synchronous count clear (wins over enable)
//   enable in  advance the count this cycle
//   tick   out high for the single cycle the count sits at TICK_DIV-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = enable && (count_q == LAST);

  // Next count: clear beats enable; the count wraps on the tick cycle
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// -----------------------------------------------------------------------------
// countdown_sequencer
// Round controller for the two-digit BCD countdown timer. Loads a clamped
// preset into the timer, issues decrement strobes every TICK_DIV cycles,
// supports pause and abort, and detects expiry from the timer's digit
// feedback. Every output is registered.
// Parameters:
//   TICK_DIV     clk cycles per decrement (>= 4)
//   WARN_THRESH  BCD tens:units at or below which warn asserts
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    countdown_sequencer_if.master (control in, feedback in, strobes
//          and status out)
// Build option:
//   COUNTDOWN_WARN_EN  when defined, warn flags a low remaining count while
//                      running; otherwise warn is held at 0.
// -----------------------------------------------------------------------------
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter logic [7:0]  WARN_THRESH = 8'h05
) (
  input  logic                         clk,
  input  logic                         reset,
  countdown_sequencer_if.master        bus
);

  cd_state_t  state_q, state_d;

  logic       reconfig_q, reconfig_d;
  bcd_digit_t setTens_q, setTens_d;
  bcd_digit_t setUnits_q, setUnits_d;
  logic       decrement_q, decrement_d;
  logic       resetTimer_q, resetTimer_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       warn_q, warn_d;
  logic       decPrev_q;

  logic       tick;
  logic       fbZero;

  assign fbZero = (bus.digit_tens == 4'd0) && (bus.digit_units == 4'd0);

  // The prescaler restarts on every load and only advances while the
  // registered state is RUN; the edge that enters PAUSE still advances it,
  // which is what lets a resumed round pick up with the held phase.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == CD_LOAD),
    .enable (state_q == CD_RUN),
    .tick   (tick)
  );

  // Next-state logic. abort always wins; start only matters in IDLE and
  // EXPIRED. Timer feedback lags a decrement by a cycle, so a zero reading
  // right after a strobe is not trusted for expiry.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = CD_IDLE;
    end else begin
      case (state_q)
        CD_IDLE: begin
          if (bus.start) state_d = CD_LOAD;
        end
        CD_LOAD: begin
          state_d = CD_RUN;
        end
        CD_RUN: begin
          if (fbZero && !decPrev_q) begin
            state_d = CD_EXPIRED;
          end else if (bus.pause) begin
            state_d = CD_PAUSE;
          end
        end
        CD_PAUSE: begin
          if (!bus.pause) state_d = CD_RUN;
        end
        CD_EXPIRED: begin
          if (bus.start) state_d = CD_LOAD;
        end
        default: begin
          state_d = CD_IDLE;
        end
      endcase
    end
  end

  // Output next values are derived from the state being entered, so the
  // registered outputs line up with the registered state. Load digits are
  // captured on entry to LOAD and held until the next load.
  always_comb begin
    reconfig_d   = (state_d == CD_LOAD);
    setTens_d    = setTens_q;
    setUnits_d   = setUnits_q;
    if (state_d == CD_LOAD) begin
      setTens_d  = bcd_clamp(bus.preset_tens);
      setUnits_d = bcd_clamp(bus.preset_units);
    end
    decrement_d  = tick && !fbZero && !bus.abort;
    resetTimer_d = bus.abort && (state_q != CD_IDLE);
    running_d    = (state_d == CD_RUN) || (state_d == CD_PAUSE);
    expired_d    = (state_d == CD_EXPIRED);
`ifdef COUNTDOWN_WARN_EN
    warn_d       = running_d && !fbZero &&
                   ({bus.digit_tens, bus.digit_units} <= WARN_THRESH);
`else
    // Threshold has no effect when the warning is compiled out
    warn_d       = 1'b0 & (|WARN_THRESH);
`endif
  end

  // State and output registers; reset clears everything without a
  // reset_timer pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CD_IDLE;
      reconfig_q   <= 1'b0;
      setTens_q    <= '0;
      setUnits_q   <= '0;
      decrement_q  <= 1'b0;
      resetTimer_q <= 1'b0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
      warn_q       <= 1'b0;
      decPrev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      reconfig_q   <= reconfig_d;
      setTens_q    <= setTens_d;
      setUnits_q   <= setUnits_d;
      decrement_q  <= decrement_d;
      resetTimer_q <= resetTimer_d;
      running_q    <= running_d;
      expired_q    <= expired_d;
      warn_q       <= warn_d;
      decPrev_q    <= decrement_q;
    end
  end

  assign bus.reconfig       = reconfig_q;
  assign bus.setDigit_tens  = setTens_q;
  assign bus.setDigit_units = setUnits_q;
  assign bus.decrement      = decrement_q;
  assign bus.reset_timer    = resetTimer_q;
  assign bus.running        = running_q;
  assign bus.expired        = expired_q;
  assign bus.warn           = warn_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// -----------------------------------------------------------------------------
// tb_countdown_sequencer
// Directed bench for countdown_sequencer with TICK_DIV = 4. A small BCD timer
// model closes the digit feedback loop. Each directed test queues the strobe
// events it expects (kind, cycle window, load digits); a negedge monitor pops
// and compares whenever the DUT raises a strobe or expired.
// -----------------------------------------------------------------------------
module tb_countdown_sequencer;

  typedef enum int {EV_RECONFIG, EV_DEC, EV_RESET, EV_EXPIRED} evKind_t;

  typedef struct {
    evKind_t    kind;
    int         lo;
    int         hi;
    logic [3:0] tens;
    logic [3:0] units;
  } expEv_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         cyc = 0;
  int         tests = 0;
  int         failures = 0;
  expEv_t     sb[$];
  logic       expPrev = 1'b0;
  logic [3:0] timerTens = 4'd0;
  logic [3:0] timerUnits = 4'd0;

  countdown_sequencer_if cdIf();

  countdown_sequencer #(
    .TICK_DIV    (4),
    .WARN_THRESH (8'h05)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cdIf)
  );

  // Free-running clock and a cycle counter used to schedule expectations
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Stand-in for the BCD countdown datapath: clear, load or decrement on
  // the edge after the strobe, giving one cycle of feedback latency
  always @(posedge clk) begin
    if (cdIf.reset_timer === 1'b1) begin
      timerTens  <= 4'd0;
      timerUnits <= 4'd0;
    end else if (cdIf.reconfig === 1'b1) begin
      timerTens  <= cdIf.setDigit_tens;
      timerUnits <= cdIf.setDigit_units;
    end else if (cdIf.decrement === 1'b1) begin
      if (timerUnits != 4'd0) begin
        timerUnits <= timerUnits - 4'd1;
      end else if (timerTens != 4'd0) begin
        timerTens  <= timerTens - 4'd1;
        timerUnits <= 4'd9;
      end
    end
  end

  assign cdIf.digit_tens  = timerTens;
  assign cdIf.digit_units = timerUnits;

  task automatic applyStimulus(input logic st, input logic pa, input logic ab,
                               input logic [3:0] pt, input logic [3:0] pu);
    cdIf.start        = st;
    cdIf.pause        = pa;
    cdIf.abort        = ab;
    cdIf.preset_tens  = pt;
    cdIf.preset_units = pu;
  endtask

  task automatic waitUntil(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkDigit(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushEv(input evKind_t kind, input int lo, input int hi,
                        input logic [3:0] tens, input logic [3:0] units);
    expEv_t e;
    e.kind  = kind;
    e.lo    = lo;
    e.hi    = hi;
    e.tens  = tens;
    e.units = units;
    sb.push_back(e);
  endtask

  // Queue n decrement strobes spaced by the prescaler period of 4
  task automatic pushDecs(input int first, input int n);
    for (int i = 0; i < n; i++) pushEv(EV_DEC, first + 4 * i, first + 4 * i, 4'd0, 4'd0);
  endtask

  task automatic scoreCheck(input evKind_t kind);
    expEv_t e;
    tests++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL sb_unexpected: got %s at cycle %0d, expected no event", kind.name(), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || cyc < e.lo || cyc > e.hi ||
          (kind == EV_RECONFIG &&
           (cdIf.setDigit_tens !== e.tens || cdIf.setDigit_units !== e.units))) begin
        failures++;
        $display("[TB] FAIL sb_event: got %s at cycle %0d digits %0h%0h, expected %s in cycles %0d..%0d digits %0h%0h",
                 kind.name(), cyc, cdIf.setDigit_tens, cdIf.setDigit_units,
                 e.kind.name(), e.lo, e.hi, e.tens, e.units);
      end
    end
  endtask

  // Monitor: every strobe and every rising edge of expired is matched
  // against the head of the expectation queue
  always @(negedge clk) begin
    if (cdIf.reconfig === 1'b1)    scoreCheck(EV_RECONFIG);
    if (cdIf.decrement === 1'b1)   scoreCheck(EV_DEC);
    if (cdIf.reset_timer === 1'b1) scoreCheck(EV_RESET);
    if (cdIf.expired === 1'b1 && !expPrev) scoreCheck(EV_EXPIRED);
    expPrev = (cdIf.expired === 1'b1);
  end

  // Directed sequence; cycle offsets from k are hand-derived from the
  // start edge (reconfig at k+1, RUN from k+2, first strobe at k+6)
  initial begin
    int k;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset = 1'b1;
    waitUntil(3);
    checkOutput("rst_reconfig",    cdIf.reconfig,    1'b0);
    checkOutput("rst_decrement",   cdIf.decrement,   1'b0);
    checkOutput("rst_reset_timer", cdIf.reset_timer, 1'b0);
    checkOutput("rst_running",     cdIf.running,     1'b0);
    checkOutput("rst_expired",     cdIf.expired,     1'b0);
    checkOutput("rst_warn",        cdIf.warn,        1'b0);
    checkDigit ("rst_set_tens",    cdIf.setDigit_tens,  4'd0);
    checkDigit ("rst_set_units",   cdIf.setDigit_units, 4'd0);
    reset = 1'b0;
    waitUntil(5);

    // Abort while idle: no strobe of any kind
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
    waitUntil(7);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    checkOutput("idle_abort_running", cdIf.running, 1'b0);

    // Preset 12: 12 strobes 4 apart, then expiry, no 13th strobe
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
    pushEv(EV_RECONFIG, k + 1, k + 1, 4'd1, 4'd2);
    pushDecs(k + 6, 12);
    pushEv(EV_EXPIRED, k + 52, k + 53, 4'd0, 4'd0);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    checkOutput("t12_running_in_load", cdIf.running, 1'b0);
    waitUntil(k + 2);
    checkOutput("t12_running", cdIf.running, 1'b1);
    waitUntil(k + 60);
    checkOutput("t12_expired", cdIf.expired, 1'b1);
    checkOutput("t12_not_running", cdIf.running, 1'b0);
    checkCount("t12_pending", sb.size(), 0);

    // Preset 00 from EXPIRED: straight to expiry, no decrement
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    pushEv(EV_RECONFIG, k + 1, k + 1, 4'd0, 4'd0);
    pushEv(EV_EXPIRED, k + 3, k + 3, 4'd0, 4'd0);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    waitUntil(k + 8);
    checkOutput("t00_expired", cdIf.expired, 1'b1);
    checkCount("t00_pending", sb.size(), 0);

    // Preset AF clamps to 99; then abort together with start in RUN
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'hA, 4'hF);
    pushEv(EV_RECONFIG, k + 1, k + 1, 4'd9, 4'd9);
    pushDecs(k + 6, 2);
    pushEv(EV_RESET, k + 13, k + 13, 4'd0, 4'd0);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'hA, 4'hF);
    waitUntil(k + 12);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'hA, 4'hF);
    waitUntil(k + 13);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'hA, 4'hF);
    checkOutput("abort_running", cdIf.running, 1'b0);
    waitUntil(k + 14);
    checkOutput("abort_strobe_single", cdIf.reset_timer, 1'b0);
    checkDigit ("abort_hold_tens", cdIf.setDigit_tens, 4'd9);
    waitUntil(k + 20);
    checkOutput("abort_idle_running", cdIf.running, 1'b0);
    checkCount("abort_pending", sb.size(), 0);

    // Preset 05 with a 20-cycle pause starting 2 cycles after a strobe
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd5);
    pushEv(EV_RECONFIG, k + 1, k + 1, 4'd0, 4'd5);
    pushDecs(k + 6, 2);
    pushDecs(k + 34, 3);
    pushEv(EV_EXPIRED, k + 44, k + 45, 4'd0, 4'd0);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
    waitUntil(k + 12);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 4'd5);
    waitUntil(k + 20);
    checkOutput("pause_running", cdIf.running, 1'b1);
    waitUntil(k + 32);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
    waitUntil(k + 40);
`ifdef COUNTDOWN_WARN_EN
    checkOutput("pause_warn_low_count", cdIf.warn, 1'b1);
`else
    checkOutput("pause_warn_disabled", cdIf.warn, 1'b0);
`endif
    waitUntil(k + 50);
    checkOutput("pause_expired", cdIf.expired, 1'b1);
    checkCount("pause_pending", sb.size(), 0);

    // Reset in the middle of a round clears every output next edge
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd1, 4'd2);
    pushEv(EV_RECONFIG, k + 1, k + 1, 4'd1, 4'd2);
    pushDecs(k + 6, 1);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    waitUntil(k + 8);
    reset = 1'b1;
    waitUntil(k + 9);
    checkOutput("mid_rst_running",     cdIf.running,     1'b0);
    checkOutput("mid_rst_reset_timer", cdIf.reset_timer, 1'b0);
    checkOutput("mid_rst_decrement",   cdIf.decrement,   1'b0);
    checkDigit ("mid_rst_set_tens",    cdIf.setDigit_tens,  4'd0);
    checkDigit ("mid_rst_set_units",   cdIf.setDigit_units, 4'd0);
    reset = 1'b0;
    waitUntil(k + 14);
    checkCount("mid_rst_pending", sb.size(), 0);

`ifdef COUNTDOWN_WARN_EN
    // Preset 07: warn rises the cycle after feedback reads 05, falls at 00
    k = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 4'd7);
    pushEv(EV_RECONFIG, k + 1, k + 1, 4'd0, 4'd7);
    pushDecs(k + 6, 7);
    pushEv(EV_EXPIRED, k + 32, k + 33, 4'd0, 4'd0);
    waitUntil(k + 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 4'd7);
    waitUntil(k + 11);
    checkOutput("warn_before", cdIf.warn, 1'b0);
    waitUntil(k + 12);
    checkOutput("warn_rise", cdIf.warn, 1'b1);
    waitUntil(k + 31);
    checkOutput("warn_at_01", cdIf.warn, 1'b1);
    waitUntil(k + 32);
    checkOutput("warn_fall", cdIf.warn, 1'b0);
    waitUntil(k + 38);
    checkCount("warn_pending", sb.size(), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
